rf_wport_arbiter: RTL and testbench

Arbiter and scoreboard for the register file's single write port (we3/wa3/wd3). It shares that port between the in-order pipeline writeback stage and one long-latency unit (multiplier/divider). Long-latency results are held in a one-entry buffer until a free write slot appears. A busy-bit scoreboard lets decode detect RAW and WAW hazards on registers whose long-latency results are still outstanding. The block sits between the writeback stage, the long-latency unit and the regfile write port.

---
 rtl/rf_wport_arbiter_pkg.sv | 21 ++
 rtl/rf_scoreboard.sv | 45 ++++
 rtl/rf_wport_arbiter.sv | 120 ++++++++++++
 tb/tb_rf_wport_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wport_arbiter_pkg.sv
// Shared sizes and types for the regfile write-port arbiter.
// Mirrors XLEN / RFIDX_WIDTH / RFREG_NUM from xgriscv_defines.v and adds RF_STARVE_MAX.
package rf_wport_arbiter_pkg;

    localparam int XLEN          = 32;
    localparam int RFIDX_WIDTH   = 5;
    localparam int RFREG_NUM     = 32;
    localparam int RF_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        WSRC_NONE = 2'd0,
        WSRC_WB   = 2'd1,
        WSRC_HB   = 2'd2
    } wsrc_t;

    typedef struct packed {
        logic [RFIDX_WIDTH-1:0] wa;
        logic [XLEN-1:0]        wd;
    } rf_wr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard for registers with outstanding long-latency writes.
// Provides the WAW issue stall and the source-operand busy lookups.
module rf_scoreboard
    import rf_wport_arbiter_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   iss_valid,
    input  logic [RFIDX_WIDTH-1:0] iss_rd,
    input  logic                   drain,
    input  logic [RFIDX_WIDTH-1:0] drain_wa,
    input  logic [RFIDX_WIDTH-1:0] rs1,
    input  logic [RFIDX_WIDTH-1:0] rs2,
    output logic                   iss_stall,
    output logic                   rs1_busy,
    output logic                   rs2_busy
);

    logic [RFREG_NUM-1:0] busy;
    logic [RFREG_NUM-1:0] busy_nxt;
    logic                 iss_accept;

    assign iss_stall  = iss_valid && (iss_rd != '0) && busy[iss_rd];
    assign iss_accept = iss_valid && !iss_stall && (iss_rd != '0);
    assign rs1_busy   = busy[rs1];
    assign rs2_busy   = busy[rs2];

    // Set is applied after clear so it wins on a same-index collision.
    always_comb begin
        busy_nxt = busy;
        if (drain)
            busy_nxt[drain_wa] = 1'b0;
        if (iss_accept)
            busy_nxt[iss_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the regfile write port between pipeline writeback and a one-entry long-latency buffer.
// Optional starvation guard enabled by defining XGRISCV_RF_STARVE_GUARD_EN.
module rf_wport_arbiter
    import rf_wport_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = RF_STARVE_MAX
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wb_we,
    input  logic [RFIDX_WIDTH-1:0] wb_wa,
    input  logic [XLEN-1:0]        wb_wd,
    output logic                   wb_stall,
    input  logic                   lu_valid,
    input  logic [RFIDX_WIDTH-1:0] lu_wa,
    input  logic [XLEN-1:0]        lu_wd,
    output logic                   lu_ready,
    input  logic                   iss_valid,
    input  logic [RFIDX_WIDTH-1:0] iss_rd,
    output logic                   iss_stall,
    input  logic [RFIDX_WIDTH-1:0] rs1,
    input  logic [RFIDX_WIDTH-1:0] rs2,
    output logic                   rs1_busy,
    output logic                   rs2_busy,
    output logic                   rf_we,
    output logic [RFIDX_WIDTH-1:0] rf_wa,
    output logic [XLEN-1:0]        rf_wd
);

    logic                   hb_v;
    logic [RFIDX_WIDTH-1:0] hb_wa;
    logic [XLEN-1:0]        hb_wd;
    logic                   guard_fire;
    logic                   drain;
    wsrc_t                  wsrc;

`ifdef XGRISCV_RF_STARVE_GUARD_EN
    localparam int SC_W = $clog2(STARVE_MAX + 1);
    logic [SC_W-1:0] sc;

    assign guard_fire = hb_v && (sc == SC_W'(STARVE_MAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sc <= '0;
        else if (!hb_v || drain)
            sc <= '0;
        else if (wsrc == WSRC_WB)
            sc <= sc + 1'b1;
    end
`else
    logic starve_unused;
    assign starve_unused = (STARVE_MAX != 0);
    assign guard_fire    = 1'b0;
`endif

    // A pipeline write to x0 is treated as an idle slot.
    always_comb begin
        wsrc = WSRC_NONE;
        if (guard_fire)
            wsrc = WSRC_HB;
        else if (wb_we && (wb_wa != '0))
            wsrc = WSRC_WB;
        else if (hb_v)
            wsrc = WSRC_HB;
    end

    always_comb begin
        rf_we = 1'b0;
        rf_wa = '0;
        rf_wd = '0;
        case (wsrc)
            WSRC_WB: begin
                rf_we = 1'b1;
                rf_wa = wb_wa;
                rf_wd = wb_wd;
            end
            WSRC_HB: begin
                rf_we = 1'b1;
                rf_wa = hb_wa;
                rf_wd = hb_wd;
            end
            default: ;
        endcase
    end

    assign drain    = (wsrc == WSRC_HB);
    assign wb_stall = guard_fire;
    assign lu_ready = !hb_v;

    // Load and drain are exclusive: a load needs an empty buffer, a drain a full one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hb_v  <= 1'b0;
            hb_wa <= '0;
            hb_wd <= '0;
        end else if (drain) begin
            hb_v <= 1'b0;
        end else if (lu_valid && lu_ready) begin
            hb_v  <= 1'b1;
            hb_wa <= lu_wa;
            hb_wd <= lu_wd;
        end
    end

    rf_scoreboard u_sb (
        .clk       (clk),
        .reset     (reset),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .drain     (drain),
        .drain_wa  (hb_wa),
        .rs1       (rs1),
        .rs2       (rs2),
        .iss_stall (iss_stall),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy)
    );

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Bench for rf_wport_arbiter: expected regfile writes queued at drive time, popped on each rf_we.
// Handles both builds of XGRISCV_RF_STARVE_GUARD_EN.
module tb_rf_wport_arbiter;
    import rf_wport_arbiter_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   wb_we;
    logic [RFIDX_WIDTH-1:0] wb_wa;
    logic [XLEN-1:0]        wb_wd;
    logic                   wb_stall;
    logic                   lu_valid;
    logic [RFIDX_WIDTH-1:0] lu_wa;
    logic [XLEN-1:0]        lu_wd;
    logic                   lu_ready;
    logic                   iss_valid;
    logic [RFIDX_WIDTH-1:0] iss_rd;
    logic                   iss_stall;
    logic [RFIDX_WIDTH-1:0] rs1;
    logic [RFIDX_WIDTH-1:0] rs2;
    logic                   rs1_busy;
    logic                   rs2_busy;
    logic                   rf_we;
    logic [RFIDX_WIDTH-1:0] rf_wa;
    logic [XLEN-1:0]        rf_wd;

    int checks = 0;
    int errors = 0;
    rf_wr_t exp_q[$];

    rf_wport_arbiter #(.STARVE_MAX(RF_STARVE_MAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_we     (wb_we),
        .wb_wa     (wb_wa),
        .wb_wd     (wb_wd),
        .wb_stall  (wb_stall),
        .lu_valid  (lu_valid),
        .lu_wa     (lu_wa),
        .lu_wd     (lu_wd),
        .lu_ready  (lu_ready),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_stall (iss_stall),
        .rs1       (rs1),
        .rs2       (rs2),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_wr(input logic [RFIDX_WIDTH-1:0] wa, input logic [XLEN-1:0] wd);
        rf_wr_t e;
        e.wa = wa;
        e.wd = wd;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Write monitor: every rf_we must match the head of the expected queue.
    always @(negedge clk) begin
        if (rf_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wr", {59'd0, rf_wa}, 64'd0);
            end else begin
                rf_wr_t e;
                e = exp_q.pop_front();
                check("wr_wa", 64'(rf_wa), 64'(e.wa));
                check("wr_wd", 64'(rf_wd), 64'(e.wd));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int k;
        reset = 1'b1;
        wb_we = 0; wb_wa = 0; wb_wd = 0;
        lu_valid = 0; lu_wa = 0; lu_wd = 0;
        iss_valid = 1; iss_rd = 5'd6; rs1 = 5'd6; rs2 = 5'd7;

        // Reset values
        @(negedge clk);
        check("rst_lu_ready", lu_ready, 1);
        check("rst_iss_stall", iss_stall, 0);
        check("rst_rs1_busy", rs1_busy, 0);
        check("rst_rs2_busy", rs2_busy, 0);
        check("rst_rf_we", rf_we, 0);
        check("rst_wb_stall", wb_stall, 0);
        next_cycle();
        reset = 1'b0;
        iss_valid = 0;

        // Idle pipeline: issue x5, result arrives, written one cycle after acceptance
        iss_valid = 1; iss_rd = 5'd5; rs1 = 5'd5; rs2 = 5'd0;
        @(negedge clk);
        check("idle_iss_stall", iss_stall, 0);
        check("idle_rs1_pre", rs1_busy, 0);
        next_cycle();
        iss_valid = 0;
        lu_valid = 1; lu_wa = 5'd5; lu_wd = 32'hDEAD;
        @(negedge clk);
        check("idle_rs1_busy", rs1_busy, 1);
        check("idle_lu_ready", lu_ready, 1);
        check("idle_no_wr_yet", rf_we, 0);
        next_cycle();
        lu_valid = 0;
        push_wr(5'd5, 32'hDEAD);
        @(negedge clk);
        check("idle_rf_we", rf_we, 1);
        check("idle_busy_until_drain", rs1_busy, 1);
        check("idle_lu_ready_full", lu_ready, 0);
        next_cycle();
        @(negedge clk);
        check("idle_busy_cleared", rs1_busy, 0);
        check("idle_lu_ready_empty", lu_ready, 1);

        // Collision: pipeline writes x3 every cycle while buffer holds x7
        next_cycle();
        iss_valid = 1; iss_rd = 5'd7;
        next_cycle();
        iss_valid = 0;
        lu_valid = 1; lu_wa = 5'd7; lu_wd = 32'h77;
        next_cycle();
        lu_valid = 0;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            wb_we = 1; wb_wa = 5'd3; wb_wd = 32'h300 + k;
`ifdef XGRISCV_RF_STARVE_GUARD_EN
            if (i == RF_STARVE_MAX) begin
                push_wr(5'd7, 32'h77);
                @(negedge clk);
                check("coll_wb_stall_pulse", wb_stall, 1);
            end else begin
                push_wr(5'd3, 32'h300 + k);
                k++;
                @(negedge clk);
                check("coll_wb_stall_low", wb_stall, 0);
            end
`else
            push_wr(5'd3, 32'h300 + k);
            k++;
            @(negedge clk);
            check("coll_wb_stall_low", wb_stall, 0);
`endif
            next_cycle();
        end
        wb_we = 0;
`ifndef XGRISCV_RF_STARVE_GUARD_EN
        push_wr(5'd7, 32'h77);
`endif
        @(negedge clk);
        check("coll_rf_wa_after", 64'(rf_wa), rf_we ? 64'd7 : 64'd0);
        next_cycle();

        // Pipeline write to x0 frees the slot for the buffer
        iss_valid = 1; iss_rd = 5'd9;
        next_cycle();
        iss_valid = 0;
        lu_valid = 1; lu_wa = 5'd9; lu_wd = 32'h99;
        next_cycle();
        lu_valid = 0;
        wb_we = 1; wb_wa = 5'd0; wb_wd = 32'h55;
        push_wr(5'd9, 32'h99);
        @(negedge clk);
        check("x0_rf_we", rf_we, 1);
        next_cycle();
        wb_we = 0;
        @(negedge clk);
        check("x0_drained", lu_ready, 1);

        // WAW on x4
        next_cycle();
        iss_valid = 1; iss_rd = 5'd4;
        @(negedge clk);
        check("waw_first_ok", iss_stall, 0);
        next_cycle();
        lu_valid = 1; lu_wa = 5'd4; lu_wd = 32'h44;
        @(negedge clk);
        check("waw_second_stall", iss_stall, 1);
        next_cycle();
        lu_valid = 0;
        push_wr(5'd4, 32'h44);
        @(negedge clk);
        check("waw_stall_drain_cycle", iss_stall, 1);
        next_cycle();
        @(negedge clk);
        check("waw_accept_after_drain", iss_stall, 0);
        next_cycle();
        iss_valid = 0; rs2 = 5'd4;
        @(negedge clk);
        check("waw_rs2_busy", rs2_busy, 1);
        lu_valid = 1; lu_wa = 5'd4; lu_wd = 32'h45;
        next_cycle();
        lu_valid = 0;
        push_wr(5'd4, 32'h45);
        next_cycle();
        @(negedge clk);
        check("waw_rs2_clear", rs2_busy, 0);

        // Back-pressure: second result held while buffer is full
        next_cycle();
        iss_valid = 1; iss_rd = 5'd10;
        next_cycle();
        iss_rd = 5'd11;
        next_cycle();
        iss_valid = 0;
        lu_valid = 1; lu_wa = 5'd10; lu_wd = 32'hA1;
        @(negedge clk);
        check("bp_ready_first", lu_ready, 1);
        next_cycle();
        lu_wa = 5'd11; lu_wd = 32'hB2;
        wb_we = 1; wb_wa = 5'd2; wb_wd = 32'h222;
        push_wr(5'd2, 32'h222);
        @(negedge clk);
        check("bp_ready_full", lu_ready, 0);
        next_cycle();
        wb_we = 0;
        push_wr(5'd10, 32'hA1);
        @(negedge clk);
        check("bp_ready_draining", lu_ready, 0);
        next_cycle();
        @(negedge clk);
        check("bp_ready_after_drain", lu_ready, 1);
        next_cycle();
        lu_valid = 0;
        push_wr(5'd11, 32'hB2);
        @(negedge clk);
        check("bp_second_written", rf_we, 1);
        next_cycle();

        // Reset while holding a result and busy bits
        iss_valid = 1; iss_rd = 5'd12;
        next_cycle();
        iss_valid = 0;
        lu_valid = 1; lu_wa = 5'd12; lu_wd = 32'hC3;
        next_cycle();
        lu_valid = 0; rs1 = 5'd12; rs2 = 5'd12;
        wb_we = 1; wb_wa = 5'd3; wb_wd = 32'h333;
        push_wr(5'd3, 32'h333);
        @(negedge clk);
        check("mid_rs1_busy_before", rs1_busy, 1);
        check("mid_lu_ready_before", lu_ready, 0);
        next_cycle();
        wb_we = 0;
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_lu_ready", lu_ready, 1);
        check("mid_rst_rs1_busy", rs1_busy, 0);
        check("mid_rst_rs2_busy", rs2_busy, 0);
        check("mid_rst_rf_we", rf_we, 0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_rf_we", rf_we, 0);
        next_cycle();

        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
